evt_group_scheduler: RTL and testbench

EVT_GROUP_SCHEDULER -- requirements
Module: evt_group_scheduler

---
 rtl/evt_group_scheduler.sv | 131 +++++++++++++
 tb/tb_evt_group_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/evt_group_scheduler.sv
// rtl/evt_group_scheduler.sv - round-robin pixel-group scheduler feeding an event FIFO
// Optional timestamp counter enabled by defining EVT_SCHED_TIMESTAMP_EN.
module evt_group_scheduler #(
    parameter int NUM_GRP    = 4,
    parameter int ADD_W      = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16,
    localparam int GID_W     = $clog2(NUM_GRP),
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1,
    localparam int DATA_W    = GID_W + 2 * ADD_W + TS_W
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [NUM_GRP-1:0]              grp_req_i,
    input  logic [NUM_GRP-1:0]              grp_active_i,
    input  logic [NUM_GRP-1:0]              grp_release_i,
    input  logic [NUM_GRP-1:0][ADD_W-1:0]   grp_x_add_i,
    input  logic [NUM_GRP-1:0][ADD_W-1:0]   grp_y_add_i,
    output logic [NUM_GRP-1:0]              grp_enable_o,
    output logic                            evt_valid_o,
    input  logic                            evt_ready_i,
    output logic [DATA_W-1:0]               evt_data_o,
    output logic [CNT_W-1:0]                fifo_count_o,
    output logic                            ovf_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SELECT     = 2'd1,
        SERVE      = 2'd2,
        WAIT_SPACE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   ptr_q, ptr_d, sel_q, sel_d, pick, idx;
    logic               found;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_next;
    logic [TS_W-1:0]    ts;
    logic               push, pop, full, wr_en;

`ifdef EVT_SCHED_TIMESTAMP_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) ts <= '0;
        else         ts <= ts + TS_W'(1);
    end
`else
    assign ts = '0;
`endif

    // Circular search starting at ptr; power-of-two NUM_GRP makes the wrap free.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_GRP; i++) begin
            idx = ptr_q + GID_W'(i);
            if (!found && grp_req_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign evt_valid_o = (count_q != '0);
    assign pop         = evt_valid_o && evt_ready_i;
    assign push        = (state_q == SERVE) && grp_active_i[sel_q];
    assign wr_en       = push && (!full || pop);
    assign count_next  = count_q + CNT_W'(wr_en) - CNT_W'(pop);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: if (|grp_req_i) state_d = SELECT;
            SELECT: begin
                if (found) begin
                    sel_d   = pick;
                    state_d = SERVE;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE: begin
                // Group hand-off wins over almost-full back-pressure.
                if (grp_release_i[sel_q] || !grp_req_i[sel_q]) begin
                    ptr_d   = sel_q + GID_W'(1);
                    state_d = SELECT;
                end else if (count_next >= CNT_W'(FIFO_DEPTH - 2)) begin
                    state_d = WAIT_SPACE;
                end
            end
            WAIT_SPACE: if (count_q <= CNT_W'(FIFO_DEPTH / 2)) state_d = SELECT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_o    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            count_q <= count_next;
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && full && !pop) ovf_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_q] <= {sel_q, grp_x_add_i[sel_q], grp_y_add_i[sel_q], ts};
    end

    // Enable decodes straight from state so an async reset drops it immediately.
    assign grp_enable_o = (state_q == SERVE) ? (NUM_GRP'(1) << sel_q) : '0;
    assign evt_data_o   = evt_valid_o ? mem[rd_ptr_q] : '0;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_evt_group_scheduler.sv
// tb/tb_evt_group_scheduler.sv - directed self-checking bench for evt_group_scheduler
module tb_evt_group_scheduler;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [3:0]       grp_req_i, grp_active_i, grp_release_i;
    logic [3:0][2:0]  grp_x_add_i, grp_y_add_i;
    logic [3:0]       grp_enable_o;
    logic             evt_valid_o, evt_ready_i;
    logic [23:0]      evt_data_o;
    logic [3:0]       fifo_count_o;
    logic             ovf_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0]  exp_hdr [4];
    logic [15:0] prev_ts;

    always #5 clk_i = ~clk_i;

    evt_group_scheduler dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .grp_req_i    (grp_req_i),
        .grp_active_i (grp_active_i),
        .grp_release_i(grp_release_i),
        .grp_x_add_i  (grp_x_add_i),
        .grp_y_add_i  (grp_y_add_i),
        .grp_enable_o (grp_enable_o),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_data_o   (evt_data_o),
        .fifo_count_o (fifo_count_o),
        .ovf_o        (ovf_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_en();
        for (int w = 0; w < 8; w++) begin
            if (grp_enable_o != 4'b0000) break;
            tick();
        end
    endtask

    initial begin
        reset_i       = 1'b1;
        grp_req_i     = '0;
        grp_active_i  = '0;
        grp_release_i = '0;
        grp_x_add_i   = '0;
        grp_y_add_i   = '0;
        evt_ready_i   = 1'b0;
        prev_ts       = '0;
        tick();
        tick();
        check("rst_enable", 32'(grp_enable_o), 0);
        check("rst_valid",  32'(evt_valid_o),  0);
        check("rst_count",  32'(fifo_count_o), 0);
        check("rst_ovf",    32'(ovf_o),        0);
        check("rst_data",   32'(evt_data_o),   0);

        // Single group, three grants then release
        reset_i   = 1'b0;
        grp_req_i = 4'b0100;
        tick();
        check("t1_select_en", 32'(grp_enable_o), 0);
        tick();
        check("t1_serve_en", 32'(grp_enable_o), 32'h4);
        grp_active_i = 4'b0100;
        grp_x_add_i[2] = 3'd5; grp_y_add_i[2] = 3'd3; tick();
        grp_x_add_i[2] = 3'd6; grp_y_add_i[2] = 3'd1; tick();
        grp_x_add_i[2] = 3'd7; grp_y_add_i[2] = 3'd2; tick();
        grp_active_i  = 4'b0000;
        grp_release_i = 4'b0100;
        check("t1_count3", 32'(fifo_count_o), 3);
        tick();
        grp_req_i     = 4'b0000;
        grp_release_i = 4'b0000;
        check("t1_release_en", 32'(grp_enable_o), 0);
        tick();
        tick();
        check("t1_idle_en",    32'(grp_enable_o), 0);
        check("t1_idle_count", 32'(fifo_count_o), 3);
        exp_hdr[0] = {2'd2, 3'd5, 3'd3};
        exp_hdr[1] = {2'd2, 3'd6, 3'd1};
        exp_hdr[2] = {2'd2, 3'd7, 3'd2};
        evt_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t1_valid", 32'(evt_valid_o), 1);
            check("t1_hdr", 32'(evt_data_o[23:16]), 32'(exp_hdr[i]));
`ifdef EVT_SCHED_TIMESTAMP_EN
            if (i > 0) check("t1_ts_step", 32'(evt_data_o[15:0]), 32'(prev_ts + 16'd1));
            prev_ts = evt_data_o[15:0];
`else
            check("t1_ts_zero", 32'(evt_data_o[15:0]), 0);
`endif
            tick();
        end
        evt_ready_i = 1'b0;
        check("t1_empty", 32'(evt_valid_o), 0);

        // Two groups, round-robin with wrap
        reset_i = 1'b1;
        tick();
        reset_i   = 1'b0;
        grp_req_i = 4'b1001;
        grp_x_add_i[0] = 3'd1; grp_y_add_i[0] = 3'd2;
        grp_x_add_i[3] = 3'd4; grp_y_add_i[3] = 3'd6;
        exp_hdr[0] = {2'd0, 3'd1, 3'd2};
        exp_hdr[1] = {2'd3, 3'd4, 3'd6};
        exp_hdr[2] = exp_hdr[0];
        exp_hdr[3] = exp_hdr[1];
        for (int k = 0; k < 4; k++) begin
            wait_en();
            check("t2_order", 32'(grp_enable_o), (k % 2 == 0) ? 32'h1 : 32'h8);
            grp_active_i  = 4'b1001;
            grp_release_i = 4'b1001;
            tick();
            grp_active_i  = 4'b0000;
            grp_release_i = 4'b0000;
        end
        grp_req_i = 4'b0000;
        tick();
        check("t2_count4", 32'(fifo_count_o), 4);
        evt_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_hdr", 32'(evt_data_o[23:16]), 32'(exp_hdr[i]));
            tick();
        end
        evt_ready_i = 1'b0;
        check("t2_empty", 32'(fifo_count_o), 0);

        // Almost-full back-pressure and resume of the same group
        reset_i = 1'b1;
        tick();
        reset_i   = 1'b0;
        grp_req_i = 4'b0010;
        wait_en();
        check("t3_en", 32'(grp_enable_o), 32'h2);
        grp_active_i = 4'b0010;
        repeat (5) tick();
        check("t3_count5", 32'(fifo_count_o), 5);
        check("t3_en5",    32'(grp_enable_o), 32'h2);
        tick();
        check("t3_count6", 32'(fifo_count_o), 6);
        check("t3_en_off", 32'(grp_enable_o), 0);
        tick();
        check("t3_wait_nopush", 32'(fifo_count_o), 6);
        evt_ready_i = 1'b1;
        tick();
        tick();
        evt_ready_i = 1'b0;
        check("t3_count4", 32'(fifo_count_o), 4);
        wait_en();
        check("t3_resume_en",    32'(grp_enable_o), 32'h2);
        check("t3_resume_count", 32'(fifo_count_o), 4);
        grp_active_i = 4'b0000;

        // Fill to full via release hand-offs, then push+pop and overflow
        for (int n = 0; n < 4; n++) begin
            wait_en();
            grp_active_i  = 4'b0010;
            grp_release_i = 4'b0010;
            tick();
            grp_active_i  = 4'b0000;
            grp_release_i = 4'b0000;
        end
        check("t4_full",     32'(fifo_count_o), 8);
        check("t4_ovf_pre",  32'(ovf_o),        0);
        wait_en();
        grp_active_i  = 4'b0010;
        grp_release_i = 4'b0010;
        evt_ready_i   = 1'b1;
        tick();
        grp_active_i  = 4'b0000;
        grp_release_i = 4'b0000;
        evt_ready_i   = 1'b0;
        check("t4_pushpop_count", 32'(fifo_count_o), 8);
        check("t4_pushpop_ovf",   32'(ovf_o),        0);
        wait_en();
        grp_active_i  = 4'b0010;
        grp_release_i = 4'b0010;
        tick();
        grp_active_i  = 4'b0000;
        grp_release_i = 4'b0000;
        check("t4_drop_count", 32'(fifo_count_o), 8);
        check("t4_ovf_set",    32'(ovf_o),        1);
        tick();
        check("t4_ovf_sticky", 32'(ovf_o),        1);

        // Asynchronous reset in the middle of SERVE
        reset_i = 1'b1;
        tick();
        reset_i   = 1'b0;
        check("t5_ovf_clear", 32'(ovf_o), 0);
        grp_req_i = 4'b0100;
        wait_en();
        grp_active_i = 4'b0100;
        repeat (3) tick();
        check("t5_count3", 32'(fifo_count_o), 3);
        check("t5_en",     32'(grp_enable_o), 32'h4);
        #2;
        reset_i = 1'b1;
        #1;
        check("t5_async_en",    32'(grp_enable_o), 0);
        check("t5_async_valid", 32'(evt_valid_o),  0);
        check("t5_async_count", 32'(fifo_count_o), 0);
        check("t5_async_data",  32'(evt_data_o),   0);
        grp_active_i = 4'b0000;
        grp_req_i    = 4'b0000;
        tick();
        reset_i = 1'b0;
        tick();
        check("t5_post_count", 32'(fifo_count_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
